// File: rtl/seg_decoder.sv
// seg_decoder: debounce a 7-seg+dp bus and decode it (clk_2, rst_n, seg_in -> digit, dp, digit_valid, blank, new_digit, err, err_count); define SEG_DECODER_HEX_EN to accept A-F
module seg_decoder #(
  parameter int NBITS_SEG = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic [NBITS_SEG-1:0] seg_in,
  output logic [3:0]           digit,
  output logic                 dp,
  output logic                 digit_valid,
  output logic                 blank,
  output logic                 new_digit,
  output logic                 err,
  output logic [7:0]           err_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [0:0] S_SETTLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  logic [NBITS_SEG-1:0] cur, locked;
  logic [CW-1:0] cnt, cnt_n;
  logic [0:0] state, state_e;
  logic changed, commit, fresh, legal, is_blank;
  logic [3:0] val;
  always_comb begin
    legal = 1'b1;
    val = 4'd0;
    case (seg_in[6:0])
      7'h3F: val = 4'd0;
      7'h06: val = 4'd1;
      7'h5B: val = 4'd2;
      7'h4F: val = 4'd3;
      7'h66: val = 4'd4;
      7'h6D: val = 4'd5;
      7'h7D: val = 4'd6;
      7'h07: val = 4'd7;
      7'h7F: val = 4'd8;
      7'h6F: val = 4'd9;
`ifdef SEG_DECODER_HEX_EN
      7'h77: val = 4'd10;
      7'h7C: val = 4'd11;
      7'h39: val = 4'd12;
      7'h5E: val = 4'd13;
      7'h79: val = 4'd14;
      7'h71: val = 4'd15;
`endif
      default: legal = 1'b0;
    endcase
  end
  // The commit decision uses the count this edge will store, so a pattern
  // sampled for the STABLE_CYCLES-th time commits on that very edge.
  assign changed  = seg_in != cur;
  assign cnt_n    = changed ? CW'(1) : (cnt == CMAX ? cnt : cnt + CW'(1));
  assign state_e  = changed ? S_SETTLE : state;
  assign commit   = state_e == S_SETTLE && cnt_n == CMAX;
  assign fresh    = commit && seg_in != locked;
  assign is_blank = seg_in[6:0] == 7'h00;
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= '0;
      cnt         <= '0;
      locked      <= '0;
      state       <= S_SETTLE;
      digit       <= 4'd0;
      dp          <= 1'b0;
      digit_valid <= 1'b0;
      blank       <= 1'b1;
      new_digit   <= 1'b0;
      err         <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      cur       <= seg_in;
      cnt       <= cnt_n;
      state     <= commit ? S_HOLD : state_e;
      new_digit <= fresh && !is_blank && legal;
      err       <= fresh && !is_blank && !legal;
      if (fresh) begin
        locked      <= seg_in;
        blank       <= is_blank;
        digit_valid <= !is_blank && legal;
        if (!is_blank && legal) begin
          digit <= val;
          dp    <= seg_in[NBITS_SEG-1];
        end
        if (!is_blank && !legal && err_count != 8'd255) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule
